// File: rtl/multi_edge_monitor.sv
// Multi-channel edge monitor: synchroniser, persistence filter, mode-gated edge events.
// Edge pulses, filtered level, sticky flags and counters all update on the filter's accept edge.
module multi_edge_monitor #(
  parameter int                  CHANNELS      = 4,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  FILTER_CYCLES = 4,
  parameter int                  COUNT_WIDTH   = 8,
  parameter logic [CHANNELS-1:0] RESET_LEVEL   = {CHANNELS{1'b0}}
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             in,
  input  logic [2*CHANNELS-1:0]           mode,
  input  logic [CHANNELS-1:0]             clear,
  output logic [CHANNELS-1:0]             filtered,
  output logic [CHANNELS-1:0]             posedge_detected,
  output logic [CHANNELS-1:0]             negedge_detected,
  output logic [CHANNELS-1:0]             event_pulse,
  output logic [CHANNELS-1:0]             event_sticky,
  output logic [CHANNELS*COUNT_WIDTH-1:0] event_count,
  output logic                            any_event
);

  localparam int                    FW       = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FW-1:0]         FLT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]    sync;
  logic [CHANNELS-1:0]    filt_q, filt_d;
  logic [FW-1:0]          flt_cnt_q [CHANNELS];
  logic [FW-1:0]          flt_cnt_d [CHANNELS];
  logic [CHANNELS-1:0]    pos_q, pos_d, neg_q, neg_d;
  logic [CHANNELS-1:0]    ev_q, ev_d, sticky_q, sticky_d;
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic                   any_q, any_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_LEVEL;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A new level is accepted only after differing from filtered for FILTER_CYCLES straight cycles.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = flt_cnt_q;
    pos_d     = '0;
    neg_d     = '0;
    ev_d      = '0;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync[i] == filt_q[i]) begin
        flt_cnt_d[i] = '0;
      end else if (flt_cnt_q[i] == FLT_LAST) begin
        filt_d[i]    = sync[i];
        flt_cnt_d[i] = '0;
        pos_d[i]     = sync[i];
        neg_d[i]     = ~sync[i];
      end else begin
        flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
      end
      ev_d[i] = (pos_d[i] & mode[2*i]) | (neg_d[i] & mode[2*i+1]);
      // An event coinciding with clear still counts, so nothing is lost.
      if (ev_d[i])       sticky_d[i] = 1'b1;
      else if (clear[i]) sticky_d[i] = 1'b0;
      if (clear[i])                          cnt_d[i] = ev_d[i] ? COUNT_WIDTH'(1) : '0;
      else if (ev_d[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
    end
    any_d = |ev_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q   <= RESET_LEVEL;
      pos_q    <= '0;
      neg_q    <= '0;
      ev_q     <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        flt_cnt_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
    end else begin
      filt_q    <= filt_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      ev_q      <= ev_d;
      sticky_q  <= sticky_d;
      any_q     <= any_d;
      flt_cnt_q <= flt_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    event_count = '0;
    for (int i = 0; i < CHANNELS; i++) event_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[i];
  end

  assign filtered         = filt_q;
  assign posedge_detected = pos_q;
  assign negedge_detected = neg_q;
  assign event_pulse      = ev_q;
  assign event_sticky     = sticky_q;
  assign any_event        = any_q;

endmodule

// File: tb/tb_multi_edge_monitor.sv
// Bench for multi_edge_monitor: directed scenarios plus random stimulus against a run-length model.
module tb_multi_edge_monitor;
  localparam int         CH   = 4;
  localparam int         S    = 2;
  localparam int         F    = 4;
  localparam int         CW   = 2;
  localparam int         MAXC = 3;
  localparam logic [3:0] RL   = 4'b0011;

  logic       clk;
  logic       rst_r;
  logic [3:0] in_r, clr_r;
  logic [7:0] mode_r;
  logic [3:0] filtered, posedge_detected, negedge_detected, event_pulse, event_sticky;
  logic [7:0] event_count;
  logic       any_event;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0] hist[$];
  logic [3:0] m_filt, m_pos, m_neg, m_ev, m_sticky;
  logic       m_any;
  int         m_run[CH];
  int         m_cnt[CH];

  multi_edge_monitor #(
    .CHANNELS(CH), .SYNC_STAGES(S), .FILTER_CYCLES(F), .COUNT_WIDTH(CW), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .reset(rst_r), .in(in_r), .mode(mode_r), .clear(clr_r),
    .filtered(filtered), .posedge_detected(posedge_detected), .negedge_detected(negedge_detected),
    .event_pulse(event_pulse), .event_sticky(event_sticky), .event_count(event_count),
    .any_event(any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: the model consumes the inputs present at the edge, then outputs are sampled #1 later.
  task automatic step();
    logic [3:0] sync_v;
    logic       ev;
    @(posedge clk);
    if (rst_r) begin
      hist.delete();
      for (int s = 0; s < S; s++) hist.push_back(RL);
      m_filt = RL; m_pos = '0; m_neg = '0; m_ev = '0; m_sticky = '0; m_any = 1'b0;
      for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_cnt[c] = 0; end
    end else begin
      sync_v = hist[S-1];
      hist.push_front(in_r);
      void'(hist.pop_back());
      m_pos = '0; m_neg = '0; m_ev = '0; m_any = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = (sync_v[c] != m_filt[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == F) begin
          m_filt[c] = sync_v[c];
          m_run[c]  = 0;
          m_pos[c]  = sync_v[c];
          m_neg[c]  = !sync_v[c];
        end
        ev = (m_pos[c] && mode_r[2*c]) || (m_neg[c] && mode_r[2*c+1]);
        m_ev[c] = ev;
        if (clr_r[c])  m_cnt[c] = ev ? 1 : 0;
        else if (ev)   m_cnt[c] = (m_cnt[c] < MAXC) ? m_cnt[c] + 1 : MAXC;
        if (ev)            m_sticky[c] = 1'b1;
        else if (clr_r[c]) m_sticky[c] = 1'b0;
        m_any = m_any | ev;
      end
    end
    #1;
  endtask

  task automatic toggle_ch(input int ch, output int npos, output int nneg, output int nev);
    npos = 0; nneg = 0; nev = 0;
    for (int ph = 0; ph < 2; ph++) begin
      in_r[ch] = (ph == 0);
      repeat (10) begin
        step();
        npos += posedge_detected[ch];
        nneg += negedge_detected[ch];
        nev  += event_pulse[ch];
      end
    end
  endtask

  task automatic test_reset();
    int edges = 0;
    rst_r = 1'b1; in_r = 4'b0011; mode_r = '0; clr_r = '0;
    repeat (3) step();
    n_cmp++; if (filtered !== 4'b0011) begin n_fail++; $display("FAIL reset_filtered: got %b expected 0011", filtered); end
    n_cmp++; if ((posedge_detected | negedge_detected) !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b/%b expected 0", posedge_detected, negedge_detected); end
    n_cmp++; if (event_count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h expected 00", event_count); end
    n_cmp++; if ({event_sticky, event_pulse, any_event} !== 9'b0) begin n_fail++; $display("FAIL reset_events: got %b %b %b expected 0", event_sticky, event_pulse, any_event); end
    rst_r = 1'b0;
    repeat (20) begin
      step();
      if ((posedge_detected | negedge_detected) != 4'b0) edges++;
    end
    n_cmp++; if (edges !== 0) begin n_fail++; $display("FAIL reset_quiet: got %0d edge cycles expected 0", edges); end
  endtask

  task automatic test_latency();
    in_r[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (posedge_detected[2] !== (k == 6)) begin n_fail++; $display("FAIL lat_pos k=%0d: got %b expected %b", k, posedge_detected[2], k == 6); end
      n_cmp++; if (filtered[2] !== (k >= 6)) begin n_fail++; $display("FAIL lat_filt k=%0d: got %b expected %b", k, filtered[2], k >= 6); end
    end
    in_r[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (negedge_detected[2] !== (k == 6)) begin n_fail++; $display("FAIL lat_neg k=%0d: got %b expected %b", k, negedge_detected[2], k == 6); end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0, hi = 0, npos = 0;
    in_r[3] = 1'b1;
    repeat (3) step();
    in_r[3] = 1'b0;
    repeat (12) begin
      step();
      pulses += posedge_detected[3] + negedge_detected[3];
      hi += filtered[3];
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL glitch_filtered: got %0d high cycles expected 0", hi); end
    in_r[3] = 1'b1;
    repeat (4) begin step(); npos += posedge_detected[3]; end
    in_r[3] = 1'b0;
    repeat (12) begin step(); npos += posedge_detected[3]; end
    n_cmp++; if (npos !== 1) begin n_fail++; $display("FAIL glitch_min_width: got %0d posedges expected 1", npos); end
  endtask

  task automatic test_mode_gating();
    int np, nn, ne;
    clr_r[2] = 1'b1; step(); clr_r[2] = 1'b0;
    mode_r[5:4] = 2'b01;
    toggle_ch(2, np, nn, ne);
    n_cmp++; if (ne !== 1) begin n_fail++; $display("FAIL mode01_events: got %0d expected 1", ne); end
    n_cmp++; if (event_count[5:4] !== 2'd1) begin n_fail++; $display("FAIL mode01_count: got %0d expected 1", event_count[5:4]); end
    mode_r[5:4] = 2'b11;
    toggle_ch(2, np, nn, ne);
    n_cmp++; if (ne !== 2) begin n_fail++; $display("FAIL mode11_events: got %0d expected 2", ne); end
    n_cmp++; if (event_count[5:4] !== 2'd3) begin n_fail++; $display("FAIL mode11_count: got %0d expected 3", event_count[5:4]); end
    mode_r[5:4] = 2'b00;
    toggle_ch(2, np, nn, ne);
    n_cmp++; if ({np, nn, ne} !== {32'd1, 32'd1, 32'd0}) begin n_fail++; $display("FAIL mode00_edges: got pos=%0d neg=%0d ev=%0d expected 1 1 0", np, nn, ne); end
    n_cmp++; if (event_count[5:4] !== 2'd3) begin n_fail++; $display("FAIL mode00_count: got %0d expected 3", event_count[5:4]); end
  endtask

  task automatic test_saturation_clear();
    int np, nn, ne;
    mode_r[7:6] = 2'b01;
    clr_r[3] = 1'b1; step(); clr_r[3] = 1'b0;
    repeat (5) toggle_ch(3, np, nn, ne);
    n_cmp++; if (event_count[7:6] !== 2'd3) begin n_fail++; $display("FAIL sat_count: got %0d expected 3", event_count[7:6]); end
    in_r[3] = 1'b1;
    repeat (5) step();
    clr_r[3] = 1'b1; step(); clr_r[3] = 1'b0;
    n_cmp++; if (event_pulse[3] !== 1'b1) begin n_fail++; $display("FAIL collide_pulse: got %b expected 1", event_pulse[3]); end
    n_cmp++; if ({event_count[7:6], event_sticky[3]} !== 3'b011) begin n_fail++; $display("FAIL collide_state: got count=%0d sticky=%b expected 1 1", event_count[7:6], event_sticky[3]); end
    in_r[3] = 1'b0;
    repeat (10) step();
    clr_r[3] = 1'b1; step(); clr_r[3] = 1'b0;
    n_cmp++; if ({event_count[7:6], event_sticky[3]} !== 3'b000) begin n_fail++; $display("FAIL clear_alone: got count=%0d sticky=%b expected 0 0", event_count[7:6], event_sticky[3]); end
  endtask

  task automatic test_multi_reset();
    int anyc = 0, allc = 0, stray = 0;
    in_r = 4'h0;
    repeat (12) step();
    mode_r = 8'hFF;
    clr_r = 4'hF; step(); clr_r = 4'h0;
    in_r = 4'hF;
    repeat (10) begin
      step();
      anyc += any_event;
      if (event_pulse === 4'hF) allc++;
    end
    n_cmp++; if (anyc !== 1 || allc !== 1) begin n_fail++; $display("FAIL multi_any: got any=%0d all=%0d expected 1 1", anyc, allc); end
    n_cmp++; if (event_count !== 8'b01010101) begin n_fail++; $display("FAIL multi_counts: got %b expected 01010101", event_count); end
    in_r = 4'h0;
    repeat (3) step();
    rst_r = 1'b1; step(); rst_r = 1'b0;
    n_cmp++; if ({filtered, event_count, event_sticky} !== {4'b0011, 8'h00, 4'h0}) begin n_fail++; $display("FAIL midreset_state: got %b %h %b expected 0011 00 0000", filtered, event_count, event_sticky); end
    for (int k = 1; k <= 8; k++) begin
      step();
      stray += (posedge_detected != 4'h0);
      n_cmp++; if (negedge_detected !== ((k == 6) ? 4'b0011 : 4'b0000)) begin n_fail++; $display("FAIL midreset_neg k=%0d: got %b expected %b", k, negedge_detected, (k == 6) ? 4'b0011 : 4'b0000); end
    end
    n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL midreset_pos: got %0d posedge cycles expected 0", stray); end
    n_cmp++; if (event_count !== 8'b00000101) begin n_fail++; $display("FAIL midreset_count: got %b expected 00000101", event_count); end
  endtask

  task automatic test_random();
    logic [7:0] exp_cnt;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) in_r[c] = ~in_r[c];
        clr_r[c] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 31) == 0) mode_r = 8'($urandom);
      rst_r = ($urandom_range(0, 299) == 0);
      step();
      exp_cnt = '0;
      for (int c = 0; c < CH; c++) exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
      n_cmp++; if (filtered !== m_filt) begin n_fail++; $display("FAIL rnd_filtered n=%0d: got %b expected %b", n, filtered, m_filt); end
      n_cmp++; if (posedge_detected !== m_pos) begin n_fail++; $display("FAIL rnd_pos n=%0d: got %b expected %b", n, posedge_detected, m_pos); end
      n_cmp++; if (negedge_detected !== m_neg) begin n_fail++; $display("FAIL rnd_neg n=%0d: got %b expected %b", n, negedge_detected, m_neg); end
      n_cmp++; if (event_pulse !== m_ev) begin n_fail++; $display("FAIL rnd_event n=%0d: got %b expected %b", n, event_pulse, m_ev); end
      n_cmp++; if (event_sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky n=%0d: got %b expected %b", n, event_sticky, m_sticky); end
      n_cmp++; if (event_count !== exp_cnt) begin n_fail++; $display("FAIL rnd_count n=%0d: got %b expected %b", n, event_count, exp_cnt); end
      n_cmp++; if (any_event !== m_any) begin n_fail++; $display("FAIL rnd_any n=%0d: got %b expected %b", n, any_event, m_any); end
    end
    rst_r = 1'b0;
  endtask

  initial begin
    rst_r = 1'b1; in_r = '0; clr_r = '0; mode_r = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_mode_gating();
    test_saturation_clear();
    test_multi_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_edge_monitor.md
# multi_edge_monitor

Parametrised multi-channel edge monitor for slow external or divided-clock signals, such as TWI SCL/SDA or slowed enables. Each channel has:
- a configurable synchroniser;
- a glitch filter that requires the level to hold for a set number of cycles;
- per-channel edge-mode selection;
- registered one-cycle edge pulses, sticky flags and saturating event counters.

It sits between the pads or slow-clock dividers and the protocol FSMs. It supersedes the single-bit edge detectors.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥1)
- FILTER_CYCLES, 4, consecutive cycles a new level must persist before acceptance (≥1; 1 = no filtering)
- COUNT_WIDTH, 8, width of each per-channel event counter (≥1)
- RESET_LEVEL, {CHANNELS{1'b0}}, per-channel level loaded into the synchroniser and filter on reset (set to 1 for idle-high lines)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high; clears all state on the next clk rising edge
- in  in  CHANNELS  raw, asynchronous channel inputs
- mode  in  2*CHANNELS  per-channel edge select, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both
- clear  in  CHANNELS  per-channel clear of sticky flag and counter
- filtered  out  CHANNELS  debounced level
- posedge_detected  out  CHANNELS  one-cycle pulse on accepted 0→1
- negedge_detected  out  CHANNELS  one-cycle pulse on accepted 1→0
- event_pulse  out  CHANNELS  one-cycle pulse on an accepted edge enabled by mode
- event_sticky  out  CHANNELS  set by event_pulse condition, held until clear
- event_count  out  CHANNELS*COUNT_WIDTH  saturating event count, channel i at [COUNT_WIDTH*i +: COUNT_WIDTH]
- any_event  out  1  OR of all event_pulse bits

## Operation

Synchroniser:
- Per channel, SYNC_STAGES flops; `in` enters stage 0.
- The output is sync.

Filter:
- State per channel: `filtered` and a counter cnt of width clog2(FILTER_CYCLES)+1.
- If sync == filtered: cnt←0.
- If sync != filtered and cnt == FILTER_CYCLES−1: filtered←sync, cnt←0. This is an "accept".
- Otherwise cnt←cnt+1.
- Any return of sync to filtered before acceptance restarts the count. Glitches shorter than FILTER_CYCLES are rejected.

Edge outputs:
- All edge outputs are registered and driven on the same edge as the accept.
- posedge_detected[i]←accept & sync.
- negedge_detected[i]←accept & ~sync.
- Otherwise 0. Pulses are always exactly one cycle.

Events:
- ev[i] = (pos & mode[2i]) | (neg & mode[2i+1]), evaluated with the mode value present at the accept edge.
- event_pulse←ev; any_event←|ev (registered, aligned with event_pulse).
- Sticky: clear & ~ev → 0; ev → 1. Simultaneous clear and ev → 1, so no event is lost.
- Counter:
  - clear & ~ev → 0
  - clear & ev → 1
  - ev alone → +1, saturating at 2^COUNT_WIDTH−1 with no wrap
  - otherwise hold
- A mode change never affects the filter, `filtered`, posedge_detected or negedge_detected. It only gates event generation.
- Channels are fully independent. Simultaneous events on multiple channels are all recorded.

Reset:
- Synchroniser stages and `filtered` load RESET_LEVEL.
- cnt, pulses, sticky, counters and any_event load 0.
- Reset dominates accept, ev and clear in the same cycle.
- A reset asserted mid-filter discards the partial count.
- After reset, an input at a level different from RESET_LEVEL produces a genuine edge after the normal latency.

## Timing
- Input-to-pulse latency: SYNC_STAGES+FILTER_CYCLES rising edges after the first edge that samples the new level into stage 0. Default: 6.
- `filtered` changes on the same edge as the pulse.
- event_pulse, any_event, sticky and count update on that same edge.
- Clear takes effect on the next edge.
- Minimum accepted pulse width at sync output: FILTER_CYCLES cycles.
- Minimum period between two accepted edges on one channel: FILTER_CYCLES cycles.
- No combinational path from any input to any output.

## Test plan
- Reset behaviour: RESET_LEVEL=4'b0011, hold reset 3 cycles with in=4'b0011 → all pulses 0, filtered=4'b0011, counts 0. Release reset → no edges within 20 cycles.
- Basic latency: defaults, ch0 in 0→1 held → posedge_detected[0] high for exactly 1 cycle, 6 edges after the sampling edge; filtered[0]=1 on the same edge. Then 1→0 → negedge_detected[0] after 6 edges.
- Glitch rejection: FILTER_CYCLES=4, ch1 high for 3 cycles, then low → no pulses, filtered[1] stays 0. High for 4 cycles → exactly one posedge.
- Mode gating: mode ch2=01, toggle 0→1→0 → event_pulse[2] only on the rise, count=1. Switch to 11 and repeat → count=3. Mode 00 → edges still pulse, count unchanged.
- Saturation and clear collision: COUNT_WIDTH=2, 5 rising events with mode 01 → count stuck at 3. Assert clear in the same cycle as the next event → count=1, sticky=1. Clear alone → count=0, sticky=0.
- Reset mid-operation and multi-channel: all 4 channels rise together → any_event one cycle, four counts=1. Assert reset halfway through a filter window → no pulse, counts 0, and the filter restarts from RESET_LEVEL.
